// File: rtl/iob_arb_pkg.sv
// Shared types and constants for the IO bus arbiter.
package iob_arb_pkg;

  // Sequencer states for one arbitrated IO bus transfer.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACTV,
    DONE,
    ERR
  } arbState_t;

  // Requester indices: front-side-bus CPU path and the secondary master.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  // Width of the REQ-state timeout counter; at least one bit even when the
  // timeout is disabled, so the counter declaration stays legal.
  function automatic int cntWidth(input int tmoCyc);
    int w;
    w = $clog2(tmoCyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iob_arb_pick.sv
// Combinational round-robin winner select for the two requesters.
module iob_arb_pick
  import iob_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // A sole requester wins outright; on contention the one that did not own
  // the bus last wins, which keeps either master from being starved.
  always_comb begin
    valid  = |req;
    winner = REQ_CPU;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[REQ_AUX]) begin
      winner = REQ_AUX;
    end
  end

endmodule

// File: rtl/iob_arb.sv
// Two-master arbiter and sequencer in front of the IO bus state machine.
// Grants the shared IOREQ/IOACTV channel, latches the winner's lane and
// direction attributes, and returns a completion or timeout pulse.
module iob_arb
  import iob_arb_pkg::*;
#(
  parameter int TMO_CYC = 1023
)
(
  input  logic C16M,
  input  logic RST,
  input  logic REQ0,
  input  logic REQ1,
  input  logic LDS0,
  input  logic UDS0,
  input  logic WE0,
  input  logic LDS1,
  input  logic UDS1,
  input  logic WE1,
  output logic ACK0,
  output logic ACK1,
  output logic BERR0,
  output logic BERR1,
  output logic IOREQ,
  input  logic IOACTV,
  output logic nLDS,
  output logic nUDS,
  output logic nWE,
  output logic SEL,
  output logic BUSY
);

  localparam int            CW       = cntWidth(TMO_CYC);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TMO_LAST = (TMO_CYC > 0) ? CW'(TMO_CYC - 1) : '0;
  localparam bit            TMO_EN   = (TMO_CYC != 0);

  arbState_t     state;
  logic          last;
  logic [CW-1:0] tmoCnt;
  logic          pickValid;
  logic          pickWinner;
  logic          winLds;
  logic          winUds;
  logic          winWe;

  iob_arb_pick uPick (
    .req    ({REQ1, REQ0}),
    .last   (last),
    .valid  (pickValid),
    .winner (pickWinner)
  );

  assign winLds = pickWinner ? LDS1 : LDS0;
  assign winUds = pickWinner ? UDS1 : UDS0;
  assign winWe  = pickWinner ? WE1  : WE0;

  // Transfer sequencer with all outputs registered. Attributes and SEL are
  // written only on a grant, so they hold through DONE/ERR and IDLE.
  always_ff @(posedge C16M or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      IOREQ  <= 1'b0;
      nLDS   <= 1'b1;
      nUDS   <= 1'b1;
      nWE    <= 1'b1;
      SEL    <= REQ_CPU;
      last   <= REQ_AUX;
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      BERR0  <= 1'b0;
      BERR1  <= 1'b0;
      BUSY   <= 1'b0;
      tmoCnt <= '0;
    end else begin
      ACK0  <= 1'b0;
      ACK1  <= 1'b0;
      BERR0 <= 1'b0;
      BERR1 <= 1'b0;
      case (state)
        IDLE: begin
          // A stale IOACTV means the IO bus block is still busy: hold off.
          if (pickValid && !IOACTV) begin
            nLDS   <= ~winLds;
            nUDS   <= ~winUds;
            nWE    <= ~winWe;
            SEL    <= pickWinner;
            IOREQ  <= 1'b1;
            BUSY   <= 1'b1;
            tmoCnt <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (IOACTV) begin
            IOREQ <= 1'b0;
            state <= ACTV;
          end else if (TMO_EN && (tmoCnt == TMO_LAST)) begin
            IOREQ <= 1'b0;
            BERR0 <= (SEL == REQ_CPU);
            BERR1 <= (SEL == REQ_AUX);
            state <= ERR;
          end else if (tmoCnt != CNT_MAX) begin
            tmoCnt <= tmoCnt + CW'(1);
          end
        end
        ACTV: begin
          // No timeout here: the IO bus block owns cycle termination.
          if (!IOACTV) begin
            ACK0  <= (SEL == REQ_CPU);
            ACK1  <= (SEL == REQ_AUX);
            state <= DONE;
          end
        end
        DONE, ERR: begin
          last  <= SEL;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          IOREQ <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_arb.sv
// Self-checking bench for iob_arb: directed scenarios plus randomized
// transfers checked against a round-robin model of the arbiter's rules.
module tb_iob_arb;

  localparam int TMO = 8;

  logic C16M   = 1'b0;
  logic RST    = 1'b1;
  logic REQ0   = 1'b0;
  logic REQ1   = 1'b0;
  logic LDS0   = 1'b0;
  logic UDS0   = 1'b0;
  logic WE0    = 1'b0;
  logic LDS1   = 1'b0;
  logic UDS1   = 1'b0;
  logic WE1    = 1'b0;
  logic IOACTV = 1'b0;
  logic ACK0, ACK1, BERR0, BERR1, IOREQ, nLDS, nUDS, nWE, SEL, BUSY;

  int total = 0;
  int bad   = 0;
  bit lastOwner;
  int xferNo = 0;

  typedef struct packed {
    int         n;
    logic       sel;
    logic [2:0] attr;
    int         hi;
    int         w;
    logic [3:0] flags;
    logic       ioreqAfter;
  } obs_t;

  iob_arb #(.TMO_CYC(TMO)) dut (
    .C16M(C16M), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .LDS0(LDS0), .UDS0(UDS0), .WE0(WE0),
    .LDS1(LDS1), .UDS1(UDS1), .WE1(WE1),
    .ACK0(ACK0), .ACK1(ACK1), .BERR0(BERR0), .BERR1(BERR1),
    .IOREQ(IOREQ), .IOACTV(IOACTV),
    .nLDS(nLDS), .nUDS(nUDS), .nWE(nWE),
    .SEL(SEL), .BUSY(BUSY)
  );

  always #5 C16M = ~C16M;

  // ---------------- reference model ----------------
  function automatic bit modelWinner(bit r0, bit r1, bit lastIdx);
    if (r0 && !r1) return 1'b0;
    if (r1 && !r0) return 1'b1;
    return !lastIdx;
  endfunction

  function automatic logic [2:0] modelAttr(bit w);
    return w ? {~LDS1, ~UDS1, ~WE1} : {~LDS0, ~UDS0, ~WE0};
  endfunction

  // {ACK0, ACK1, BERR0, BERR1}
  function automatic logic [3:0] modelFlags(bit w, bit err);
    if (err) return w ? 4'b0001 : 4'b0010;
    return w ? 4'b0100 : 4'b1000;
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic tick();
    @(posedge C16M);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (IOREQ !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Raise IOACTV so that it is first sampled d edges after the grant.
  task automatic run_req_phase(input int d, output int hi);
    hi = 0;
    for (int i = 0; i < d; i++) begin
      if (IOREQ === 1'b1) hi++;
      if (i == d - 1) IOACTV = 1'b1;
      tick();
    end
  endtask

  task automatic run_actv(input int len, output int w, output logic [3:0] flags);
    for (int i = 0; i < len - 1; i++) tick();
    IOACTV = 1'b0;
    w = 0;
    flags = 4'b0;
    do begin
      tick();
      w++;
      flags = {ACK0, ACK1, BERR0, BERR1};
    end while (flags == 4'b0 && w < 20);
  endtask

  task automatic run_timeout(output int hi, output int w, output logic [3:0] flags);
    hi = 0;
    w = 0;
    flags = 4'b0;
    while (w < 60) begin
      if (IOREQ === 1'b1) hi++;
      tick();
      w++;
      flags = {ACK0, ACK1, BERR0, BERR1};
      if (flags != 4'b0) break;
    end
  endtask

  task automatic do_xfer(input int d, input int len, input bit tmo, output obs_t o);
    int n, hi, w;
    logic [3:0] fl;
    wait_grant(n);
    o.n    = n;
    o.sel  = SEL;
    o.attr = {nLDS, nUDS, nWE};
    if (tmo) begin
      run_timeout(hi, w, fl);
      o.ioreqAfter = IOREQ;
    end else begin
      run_req_phase(d, hi);
      o.ioreqAfter = IOREQ;
      run_actv(len, w, fl);
    end
    o.hi    = hi;
    o.w     = w;
    o.flags = fl;
    xferNo++;
    $display("xfer %0d: sel=%0d attr=%b ioreq_cycles=%0d flags=%b latency=%0d",
             xferNo, o.sel, o.attr, o.hi, o.flags, o.w);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; IOACTV = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (2) tick();
    total++;
    if ({IOREQ, nLDS, nUDS, nWE, SEL, BUSY, ACK0, ACK1, BERR0, BERR1} !== 10'b0111000000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b",
               {IOREQ, nLDS, nUDS, nWE, SEL, BUSY, ACK0, ACK1, BERR0, BERR1}, 10'b0111000000);
    end
    RST = 1'b0;
    tick();
    total++;
    if ({IOREQ, BUSY} !== 2'b00) begin
      bad++; $display("FAIL reset_idle: got %b want 00", {IOREQ, BUSY});
    end
    lastOwner = 1'b1;
  endtask

  task automatic test_single();
    obs_t o;
    logic [2:0] ea;
    REQ0 = 1'b1; REQ1 = 1'b0; LDS0 = 1'b1; UDS0 = 1'b0; WE0 = 1'b1;
    ea = modelAttr(1'b0);
    do_xfer(3, 10, 1'b0, o);
    total++; if (o.n !== 1) begin bad++; $display("FAIL single_grant_latency: got %0d want 1", o.n); end
    total++; if ({o.attr, o.sel} !== {ea, 1'b0}) begin bad++; $display("FAIL single_attr_sel: got %b want %b", {o.attr, o.sel}, {ea, 1'b0}); end
    total++; if (o.hi !== 3) begin bad++; $display("FAIL single_ioreq_len: got %0d want 3", o.hi); end
    total++; if (o.ioreqAfter !== 1'b0) begin bad++; $display("FAIL single_ioreq_drop: got %b want 0", o.ioreqAfter); end
    total++; if (o.w !== 1) begin bad++; $display("FAIL single_ack_latency: got %0d want 1", o.w); end
    total++; if (o.flags !== modelFlags(1'b0, 1'b0)) begin bad++; $display("FAIL single_ack_flags: got %b want %b", o.flags, modelFlags(1'b0, 1'b0)); end
    REQ0 = 1'b0;
    tick();
    total++; if ({ACK0, ACK1, BUSY} !== 3'b000) begin bad++; $display("FAIL single_ack_pulse: got %b want 000", {ACK0, ACK1, BUSY}); end
    lastOwner = 1'b0;
  endtask

  task automatic test_simultaneous();
    obs_t o;
    bit w;
    RST = 1'b1; tick(); RST = 1'b0; tick();
    lastOwner = 1'b1;
    LDS0 = 1'b1; UDS0 = 1'b1; WE0 = 1'b0;
    LDS1 = 1'b0; UDS1 = 1'b1; WE1 = 1'b1;
    REQ0 = 1'b1; REQ1 = 1'b1;
    w = modelWinner(1'b1, 1'b1, lastOwner);
    do_xfer(2, 2, 1'b0, o);
    total++; if (o.sel !== w) begin bad++; $display("FAIL simul_first_sel: got %0d want %0d", o.sel, w); end
    total++; if (o.flags !== modelFlags(w, 1'b0)) begin bad++; $display("FAIL simul_first_ack: got %b want %b", o.flags, modelFlags(w, 1'b0)); end
    lastOwner = w;
    if (w) REQ1 = 1'b0; else REQ0 = 1'b0;
    tick();
    w = modelWinner(REQ0, REQ1, lastOwner);
    do_xfer(1, 1, 1'b0, o);
    total++; if ({o.sel, o.attr} !== {w, modelAttr(w)}) begin bad++; $display("FAIL simul_second: got %b want %b", {o.sel, o.attr}, {w, modelAttr(w)}); end
    total++; if (o.flags !== modelFlags(w, 1'b0)) begin bad++; $display("FAIL simul_second_ack: got %b want %b", o.flags, modelFlags(w, 1'b0)); end
    lastOwner = w;
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    obs_t o;
    bit w;
    logic prevSel;
    REQ0 = 1'b1; REQ1 = 1'b1;
    prevSel = lastOwner;
    for (int k = 0; k < 5; k++) begin
      w = modelWinner(1'b1, 1'b1, lastOwner);
      do_xfer($urandom_range(1, 4), $urandom_range(1, 3), 1'b0, o);
      total++; if (o.n !== 1) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 1", k, o.n); end
      total++; if (o.sel !== w || o.sel === prevSel) begin bad++; $display("FAIL b2b_sel[%0d]: got %0d want %0d", k, o.sel, w); end
      prevSel = o.sel;
      lastOwner = w;
      tick();
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    obs_t o;
    bit w;
    logic [2:0] ea;
    IOACTV = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b0; LDS0 = 1'b0; UDS0 = 1'b1; WE0 = 1'b1;
    ea = modelAttr(1'b0);
    do_xfer(0, 0, 1'b1, o);
    total++; if (o.w !== TMO) begin bad++; $display("FAIL tmo_delay: got %0d want %0d", o.w, TMO); end
    total++; if (o.hi !== TMO) begin bad++; $display("FAIL tmo_ioreq_len: got %0d want %0d", o.hi, TMO); end
    total++; if (o.flags !== modelFlags(1'b0, 1'b1)) begin bad++; $display("FAIL tmo_berr: got %b want %b", o.flags, modelFlags(1'b0, 1'b1)); end
    total++; if ({IOREQ, nLDS, nUDS, nWE} !== {1'b0, ea}) begin bad++; $display("FAIL tmo_state: got %b want %b", {IOREQ, nLDS, nUDS, nWE}, {1'b0, ea}); end
    lastOwner = 1'b0;
    REQ1 = 1'b1;
    tick();
    total++; if ({BERR0, BERR1, IOREQ} !== 3'b000) begin bad++; $display("FAIL tmo_pulse: got %b want 000", {BERR0, BERR1, IOREQ}); end
    w = modelWinner(1'b1, 1'b1, lastOwner);
    do_xfer(2, 2, 1'b0, o);
    total++; if (o.sel !== w) begin bad++; $display("FAIL tmo_next_sel: got %0d want %0d", o.sel, w); end
    lastOwner = w;
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int n, hi, w;
    logic [3:0] fl;
    REQ0 = 1'b0; REQ1 = 1'b1; LDS1 = 1'b1; UDS1 = 1'b1; WE1 = 1'b1;
    wait_grant(n);
    run_req_phase(2, hi);
    tick();
    total++; if ({BUSY, SEL, nLDS, nUDS, nWE} !== 5'b11000) begin bad++; $display("FAIL arst_pre: got %b want 11000", {BUSY, SEL, nLDS, nUDS, nWE}); end
    #3 RST = 1'b1;
    #1;
    total++;
    if ({IOREQ, nLDS, nUDS, nWE, SEL, BUSY, ACK0, ACK1, BERR0, BERR1} !== 10'b0111000000) begin
      bad++;
      $display("FAIL arst_outputs: got %b want %b",
               {IOREQ, nLDS, nUDS, nWE, SEL, BUSY, ACK0, ACK1, BERR0, BERR1}, 10'b0111000000);
    end
    #1 RST = 1'b0;
    lastOwner = 1'b1;
    REQ0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({IOREQ, BUSY} !== 2'b00) begin bad++; $display("FAIL arst_stale_hold[%0d]: got %b want 00", k, {IOREQ, BUSY}); end
    end
    IOACTV = 1'b0;
    wait_grant(n);
    total++; if (n !== 1 || SEL !== modelWinner(1'b1, 1'b1, lastOwner)) begin bad++; $display("FAIL arst_first_grant: got n=%0d sel=%0d want n=1 sel=0", n, SEL); end
    run_req_phase(1, hi);
    run_actv(1, w, fl);
    total++; if (fl !== modelFlags(1'b0, 1'b0)) begin bad++; $display("FAIL arst_ack: got %b want %b", fl, modelFlags(1'b0, 1'b0)); end
    lastOwner = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_attr_hold();
    int n, hi, w;
    logic [3:0] fl;
    REQ0 = 1'b0; REQ1 = 1'b1; LDS1 = 1'b1; UDS1 = 1'b0; WE1 = 1'b0;
    wait_grant(n);
    run_req_phase(2, hi);
    WE1 = 1'b1; LDS1 = 1'b0;
    repeat (2) tick();
    total++; if ({nLDS, nUDS, nWE} !== 3'b011) begin bad++; $display("FAIL attr_hold_actv: got %b want 011", {nLDS, nUDS, nWE}); end
    run_actv(2, w, fl);
    REQ1 = 1'b0;
    tick(); tick();
    total++; if ({nLDS, nUDS, nWE, SEL} !== 4'b0111) begin bad++; $display("FAIL attr_hold_idle: got %b want 0111", {nLDS, nUDS, nWE, SEL}); end
    lastOwner = 1'b1;
    REQ1 = 1'b1;
    wait_grant(n);
    total++; if ({nLDS, nUDS, nWE} !== modelAttr(1'b1)) begin bad++; $display("FAIL attr_regrant: got %b want %b", {nLDS, nUDS, nWE}, modelAttr(1'b1)); end
    run_req_phase(1, hi);
    run_actv(1, w, fl);
    REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    obs_t o;
    bit w, r0, r1, tmo;
    int d;
    logic [2:0] ea;
    for (int k = 0; k < 20; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      LDS0 = 1'($urandom_range(0, 1)); UDS0 = 1'($urandom_range(0, 1)); WE0 = 1'($urandom_range(0, 1));
      LDS1 = 1'($urandom_range(0, 1)); UDS1 = 1'($urandom_range(0, 1)); WE1 = 1'($urandom_range(0, 1));
      REQ0 = r0; REQ1 = r1;
      tmo = ($urandom_range(0, 4) == 0);
      d = $urandom_range(1, 6);
      w = modelWinner(r0, r1, lastOwner);
      ea = modelAttr(w);
      do_xfer(d, $urandom_range(1, 5), tmo, o);
      total++; if ({o.sel, o.attr} !== {w, ea}) begin bad++; $display("FAIL rand_grant[%0d]: got %b want %b", k, {o.sel, o.attr}, {w, ea}); end
      total++; if (o.hi !== (tmo ? TMO : d)) begin bad++; $display("FAIL rand_ioreq_len[%0d]: got %0d want %0d", k, o.hi, tmo ? TMO : d); end
      total++; if (o.flags !== modelFlags(w, tmo)) begin bad++; $display("FAIL rand_flags[%0d]: got %b want %b", k, o.flags, modelFlags(w, tmo)); end
      lastOwner = w;
      REQ0 = 1'b0; REQ1 = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_attr_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
